snitch_mem_arbiter: RTL and testbench
=====================================

// Module: snitch_mem_arbiter
// PURPOSE
//   Shares one 64-bit memory port between the Snitch instruction-fetch port and data port.
//   Sits in the Snitch test harness, between the core and the single external memory interface.
//   Grants one requester at a time and holds the grant until the memory accepts.
//   Buffers one data read response so the core can back-pressure it.
//   Uses a starvation counter so data traffic cannot lock out instruction fetch.
// PARAMETERS
//   AddrWidth      32  address width of all ports
//   DataWidth      64  data port / memory data width
//   InstWidth      32  instruction word width; DataWidth/InstWidth words per memory beat
//   MaxDataStreak  4   consecutive data grants allowed while inst_valid_i is pending (>=1)
// PORTS
//   clk_i          in   1          clock, all state on rising edge
//   rst_ni         in   1          asynchronous active-low reset
//   inst_addr_i    in   AddrWidth  fetch address
//   inst_valid_i   in   1          fetch request
//   inst_ready_o   out  1          fetch done; inst_data_o valid this cycle
//   inst_data_o    out  InstWidth  fetched word
//   data_qaddr_i   in   AddrWidth  data request address
//   data_qwrite_i  in   1          1=store, 0=load
//   data_qamo_i    in   4          AMO opcode; 0=plain access
//   data_qdata_i   in   DataWidth  store data
//   data_qstrb_i   in   DataWidth/8 store byte strobes
//   data_qvalid_i  in   1          data request valid
//   data_qready_o  out  1          data request accepted
//   data_pdata_o   out  DataWidth  load response data
//   data_perror_o  out  1          response error
//   data_pvalid_o  out  1          response valid
//   data_pready_i  in   1          response accepted
//   mem_valid_o    out  1          memory request valid
//   mem_addr_o     out  AddrWidth  memory address (requester address unmodified)
//   mem_write_o    out  1          memory write
//   mem_wdata_o    out  DataWidth  write data
//   mem_wstrb_o    out  DataWidth/8 write strobes; 0 on reads
//   mem_ready_i    in   1          memory completes the transfer; mem_rdata_i is valid this cycle
//   mem_rdata_i    in   DataWidth  read data
// BEHAVIOUR
//   - Reset: every output is 0. lock=NONE, streak=0, rsp_valid=0.
//   - lock is NONE, INST or DATA.
//     - NONE: the grant is chosen combinationally and mem_valid_o is driven in the same cycle (zero latency).
//     - If mem_ready_i=1 in that same cycle, the transfer completes and lock stays NONE.
//     - Otherwise lock takes the granted owner and holds it until mem_ready_i.
//     - While locked, all mem_* outputs come from the owner and are held stable. No re-arbitration.
//   - Data is eligible when data_qvalid_i=1, data_qamo_i=0, and the request is either:
//     - a store, or
//     - a load with rsp_valid=0, or rsp_valid=1 and data_pready_i=1 in the same cycle.
//   - Priority: data wins. Inst wins when streak==MaxDataStreak and inst_valid_i=1, or when data is not eligible.
//   - streak counter:
//     - +1 (saturating) on each completed data grant while inst_valid_i=1.
//     - Cleared on each completed inst grant, and whenever inst_valid_i=0.
//   - Inst completion (owner INST and mem_ready_i):
//     - inst_ready_o=1.
//     - inst_data_o = InstWidth slice of mem_rdata_i selected by inst_addr_i[log2(DataWidth/8)-1:log2(InstWidth/8)].
//     - inst_ready_o=0 and inst_data_o=0 in every other cycle.
//   - Data completion (owner DATA and mem_ready_i): data_qready_o=1.
//     - Store: no response.
//     - Load: rsp_data<=mem_rdata_i, rsp_error<=0, rsp_valid<=1.
//   - AMO (data_qamo_i!=0): no memory access.
//     - When the response buffer is free, data_qready_o=1 and the buffer loads rsp_error=1, rsp_data=0.
//     - Inst may use the memory in the same cycle.
//   - Response: data_pvalid_o=rsp_valid; the response is held stable until data_pready_i.
//     - On pready with no new load: rsp_valid<=0.
//     - Drain and refill in the same cycle are allowed; the buffer then holds the new data.
//   - Write/read of the memory port is never issued for a requester whose valid is low.
//     - Requesters must hold their requests stable until ready; the arbiter does not check this.
//   - Async reset mid-transfer: the outstanding grant and the buffered response are discarded.
//     Outputs are 0 immediately.
// TESTING
//   1. After reset, data load @0x100 and inst @0x10004 both valid, mem_ready_i=1, pready=1, rdata=0xAAAA_BBBB_CCCC_DDDD
//      -> cycle0 data granted, pvalid next cycle with that data; cycle1 inst granted, inst_data_o=0xAAAA_BBBB.
//   2. data_qvalid_i held high, inst_valid_i high, mem_ready_i=1, MaxDataStreak=4
//      -> exactly 4 data grants, then 1 inst grant, then streak restarts.
//   3. Load completes, data_pready_i=0 for 3 cycles; second load pending, inst pending
//      -> pvalid and pdata held; second load blocked; inst granted meanwhile; second load issued in the pready cycle.
//   4. Inst granted, mem_ready_i=0 for 5 cycles, store to 0x200 arrives at cycle 1
//      -> mem_addr_o stays on the inst address for 5 cycles; the store is issued in the cycle after inst_ready_o.
//   5. data_qamo_i=4'h2 load
//      -> mem_valid_o never asserted for it; qready=1; next cycle pvalid=1, perror=1, pdata=0.
//   6. rst_ni low in cycle 2 of a stalled data grant
//      -> all outputs 0 asynchronously; after release, the request is re-arbitrated from NONE.

Source files
------------

// File: rtl/snitch_mem_arbiter_if.sv
// Bundle of the fetch port, data port and single memory port around the Snitch memory arbiter.
// slave is the arbiter's view; master is the core/memory side (test harness).
interface snitch_mem_arbiter_if #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned InstWidth = 32
);
  logic [AddrWidth-1:0]   inst_addr_i;
  logic                   inst_valid_i;
  logic                   inst_ready_o;
  logic [InstWidth-1:0]   inst_data_o;

  logic [AddrWidth-1:0]   data_qaddr_i;
  logic                   data_qwrite_i;
  logic [3:0]             data_qamo_i;
  logic [DataWidth-1:0]   data_qdata_i;
  logic [DataWidth/8-1:0] data_qstrb_i;
  logic                   data_qvalid_i;
  logic                   data_qready_o;
  logic [DataWidth-1:0]   data_pdata_o;
  logic                   data_perror_o;
  logic                   data_pvalid_o;
  logic                   data_pready_i;

  logic                   mem_valid_o;
  logic [AddrWidth-1:0]   mem_addr_o;
  logic                   mem_write_o;
  logic [DataWidth-1:0]   mem_wdata_o;
  logic [DataWidth/8-1:0] mem_wstrb_o;
  logic                   mem_ready_i;
  logic [DataWidth-1:0]   mem_rdata_i;

  modport slave (
    input  inst_addr_i, inst_valid_i,
    output inst_ready_o, inst_data_o,
    input  data_qaddr_i, data_qwrite_i, data_qamo_i, data_qdata_i, data_qstrb_i, data_qvalid_i,
    output data_qready_o, data_pdata_o, data_perror_o, data_pvalid_o,
    input  data_pready_i,
    output mem_valid_o, mem_addr_o, mem_write_o, mem_wdata_o, mem_wstrb_o,
    input  mem_ready_i, mem_rdata_i
  );

  modport master (
    output inst_addr_i, inst_valid_i,
    input  inst_ready_o, inst_data_o,
    output data_qaddr_i, data_qwrite_i, data_qamo_i, data_qdata_i, data_qstrb_i, data_qvalid_i,
    input  data_qready_o, data_pdata_o, data_perror_o, data_pvalid_o,
    output data_pready_i,
    input  mem_valid_o, mem_addr_o, mem_write_o, mem_wdata_o, mem_wstrb_o,
    output mem_ready_i, mem_rdata_i
  );
endinterface

// File: rtl/snitch_mem_arbiter.sv
// Shares one memory port between Snitch fetch and data ports: zero-latency grant, lock until
// mem_ready, one-entry load response buffer, and a streak limit so fetch is never starved.
module snitch_mem_arbiter #(
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 64,
  parameter int unsigned InstWidth     = 32,
  parameter int unsigned MaxDataStreak = 4
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  snitch_mem_arbiter_if.slave bus
);
  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned NumWords  = DataWidth / InstWidth;
  localparam int unsigned SelWidth  = (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam int unsigned SelLsb    = $clog2(InstWidth / 8);
  localparam int unsigned StreakW   = $clog2(MaxDataStreak + 1);

  typedef enum logic [1:0] {LOCK_NONE, LOCK_INST, LOCK_DATA} lock_e;

  lock_e                r_lock, w_lock_nxt;
  logic [StreakW-1:0]   r_streak;
  logic                 r_rsp_valid;
  logic                 r_rsp_error;
  logic [DataWidth-1:0] r_rsp_data;

  logic                 w_buf_free, w_data_elig, w_amo_fire, w_streak_max;
  logic                 w_pick_data, w_pick_inst, w_own_data, w_own_inst;
  logic                 w_done_data, w_done_inst, w_wr;
  logic [SelWidth-1:0]  w_word_sel;

  if (NumWords > 1) begin : g_sel
    assign w_word_sel = bus.inst_addr_i[SelLsb +: SelWidth];
  end else begin : g_nosel
    assign w_word_sel = '0;
  end

  always_comb begin
    // A draining response frees the buffer for a same-cycle refill.
    w_buf_free   = !r_rsp_valid || bus.data_pready_i;
    w_data_elig  = bus.data_qvalid_i && (bus.data_qamo_i == 4'h0) &&
                   (bus.data_qwrite_i || w_buf_free);
    w_amo_fire   = bus.data_qvalid_i && (bus.data_qamo_i != 4'h0) && w_buf_free &&
                   (r_lock != LOCK_DATA);
    w_streak_max = (r_streak == StreakW'(MaxDataStreak));
    w_pick_data  = w_data_elig && !(w_streak_max && bus.inst_valid_i);
    w_pick_inst  = bus.inst_valid_i && !w_pick_data;
    w_own_data   = (r_lock == LOCK_DATA) || ((r_lock == LOCK_NONE) && w_pick_data);
    w_own_inst   = (r_lock == LOCK_INST) || ((r_lock == LOCK_NONE) && w_pick_inst);
    w_done_data  = w_own_data && bus.mem_ready_i;
    w_done_inst  = w_own_inst && bus.mem_ready_i;
    w_wr         = w_own_data && bus.data_qwrite_i;

    w_lock_nxt = r_lock;
    if (w_done_data || w_done_inst)  w_lock_nxt = LOCK_NONE;
    else if (r_lock == LOCK_NONE) begin
      if (w_own_data)      w_lock_nxt = LOCK_DATA;
      else if (w_own_inst) w_lock_nxt = LOCK_INST;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lock      <= LOCK_NONE;
      r_streak    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_error <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_lock <= w_lock_nxt;

      if (!bus.inst_valid_i || w_done_inst)  r_streak <= '0;
      else if (w_done_data && !w_streak_max) r_streak <= r_streak + 1'b1;

      if (w_done_data && !bus.data_qwrite_i) begin
        r_rsp_valid <= 1'b1;
        r_rsp_error <= 1'b0;
        r_rsp_data  <= bus.mem_rdata_i;
      end else if (w_amo_fire) begin
        r_rsp_valid <= 1'b1;
        r_rsp_error <= 1'b1;
        r_rsp_data  <= '0;
      end else if (r_rsp_valid && bus.data_pready_i) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  // Outputs are gated by rst_ni so they drop the instant reset asserts.
  assign bus.mem_valid_o   = rst_ni && (w_own_data || w_own_inst);
  assign bus.mem_addr_o    = !rst_ni    ? '0 :
                             w_own_data ? bus.data_qaddr_i :
                             w_own_inst ? bus.inst_addr_i : '0;
  assign bus.mem_write_o   = rst_ni && w_wr;
  assign bus.mem_wdata_o   = (rst_ni && w_wr) ? bus.data_qdata_i : '0;
  assign bus.mem_wstrb_o   = (rst_ni && w_wr) ? bus.data_qstrb_i : StrbWidth'(0);

  assign bus.inst_ready_o  = rst_ni && w_done_inst;
  assign bus.inst_data_o   = (rst_ni && w_done_inst) ?
                             bus.mem_rdata_i[w_word_sel*InstWidth +: InstWidth] : '0;

  assign bus.data_qready_o = rst_ni && (w_done_data || w_amo_fire);
  assign bus.data_pvalid_o = r_rsp_valid;
  assign bus.data_perror_o = r_rsp_error;
  assign bus.data_pdata_o  = r_rsp_data;
endmodule

// File: tb/tb_snitch_mem_arbiter.sv
// Directed bench for snitch_mem_arbiter: a combinational vector table from the reset state,
// then hand-written multi-cycle sequences for streak, back-pressure, lock hold, AMO and reset.
module tb_snitch_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  snitch_mem_arbiter_if #(.AddrWidth(32), .DataWidth(64), .InstWidth(32)) bus ();

  snitch_mem_arbiter #(
    .AddrWidth(32), .DataWidth(64), .InstWidth(32), .MaxDataStreak(4)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  localparam logic [63:0] RD = 64'hAAAA_BBBB_CCCC_DDDD;
  localparam logic [63:0] WD = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] R1 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] R2 = 64'h5555_6666_7777_8888;

  typedef struct {
    logic iv; logic [31:0] ia;
    logic dv; logic dw; logic [3:0] amo; logic [31:0] da; logic [7:0] strb; logic [63:0] wd;
    logic mr; logic [63:0] rd;
    logic e_mv; logic [31:0] e_ma; logic e_mw; logic [7:0] e_ws; logic [63:0] e_wd;
    logic e_ir; logic [31:0] e_id; logic e_qr;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clr_in();
    bus.inst_addr_i   = '0; bus.inst_valid_i  = 1'b0;
    bus.data_qaddr_i  = '0; bus.data_qwrite_i = 1'b0; bus.data_qamo_i = 4'h0;
    bus.data_qdata_i  = '0; bus.data_qstrb_i  = '0;   bus.data_qvalid_i = 1'b0;
    bus.data_pready_i = 1'b0;
    bus.mem_ready_i   = 1'b0; bus.mem_rdata_i = '0;
  endtask

  // Leaves the bench at a negedge with reset released and all inputs idle.
  task automatic do_reset();
    clr_in();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vt[0] = '{0,32'h0,    0,0,4'h0,32'h0,  8'h00,64'h0,0,RD, 0,32'h0,    0,8'h00,64'h0,0,32'h0,0};
    vt[1] = '{1,32'h10004,0,0,4'h0,32'h0,  8'h00,64'h0,1,RD, 1,32'h10004,0,8'h00,64'h0,1,32'hAAAABBBB,0};
    vt[2] = '{1,32'h10000,0,0,4'h0,32'h0,  8'h00,64'h0,1,RD, 1,32'h10000,0,8'h00,64'h0,1,32'hCCCCDDDD,0};
    vt[3] = '{1,32'h10004,1,0,4'h0,32'h100,8'hFF,WD,   1,RD, 1,32'h100,  0,8'h00,64'h0,0,32'h0,1};
    vt[4] = '{0,32'h0,    1,1,4'h0,32'h200,8'h0F,WD,   0,RD, 1,32'h200,  1,8'h0F,WD,   0,32'h0,0};
    vt[5] = '{1,32'h10004,1,0,4'h2,32'h400,8'h00,64'h0,1,RD, 1,32'h10004,0,8'h00,64'h0,1,32'hAAAABBBB,1};
    vt[6] = '{1,32'h10000,0,0,4'h0,32'h0,  8'h00,64'h0,0,RD, 1,32'h10000,0,8'h00,64'h0,0,32'h0,0};
    vt[7] = '{1,32'h10000,1,1,4'h0,32'h208,8'h3C,WD,   1,RD, 1,32'h208,  1,8'h3C,WD,   0,32'h0,1};

    clr_in();
    #1;
    chk("reset_mem_valid", 64'(bus.mem_valid_o), 64'd0);
    chk("reset_pvalid", 64'(bus.data_pvalid_o), 64'd0);
    chk("reset_qready", 64'(bus.data_qready_o), 64'd0);

    // Combinational table, each vector from a fresh reset state.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      bus.inst_valid_i = vt[i].iv;  bus.inst_addr_i  = vt[i].ia;
      bus.data_qvalid_i = vt[i].dv; bus.data_qwrite_i = vt[i].dw; bus.data_qamo_i = vt[i].amo;
      bus.data_qaddr_i = vt[i].da;  bus.data_qstrb_i = vt[i].strb; bus.data_qdata_i = vt[i].wd;
      bus.mem_ready_i = vt[i].mr;   bus.mem_rdata_i  = vt[i].rd;
      #2;
      chk($sformatf("v%0d_mem_valid", i), 64'(bus.mem_valid_o),  64'(vt[i].e_mv));
      chk($sformatf("v%0d_mem_addr", i),  64'(bus.mem_addr_o),   64'(vt[i].e_ma));
      chk($sformatf("v%0d_mem_write", i), 64'(bus.mem_write_o),  64'(vt[i].e_mw));
      chk($sformatf("v%0d_mem_wstrb", i), 64'(bus.mem_wstrb_o),  64'(vt[i].e_ws));
      chk($sformatf("v%0d_mem_wdata", i), bus.mem_wdata_o,       vt[i].e_wd);
      chk($sformatf("v%0d_inst_ready", i),64'(bus.inst_ready_o), 64'(vt[i].e_ir));
      chk($sformatf("v%0d_inst_data", i), 64'(bus.inst_data_o),  64'(vt[i].e_id));
      chk($sformatf("v%0d_qready", i),    64'(bus.data_qready_o),64'(vt[i].e_qr));
      @(negedge clk);
    end

    // Load and fetch together: data first, then fetch with the upper word.
    do_reset();
    bus.data_qvalid_i = 1'b1; bus.data_qaddr_i = 32'h100;
    bus.inst_valid_i = 1'b1;  bus.inst_addr_i = 32'h10004;
    bus.mem_ready_i = 1'b1;   bus.data_pready_i = 1'b1; bus.mem_rdata_i = RD;
    #2;
    chk("s1_c0_addr", 64'(bus.mem_addr_o), 64'h100);
    chk("s1_c0_qready", 64'(bus.data_qready_o), 64'd1);
    @(negedge clk);
    bus.data_qvalid_i = 1'b0;
    #2;
    chk("s1_c1_pvalid", 64'(bus.data_pvalid_o), 64'd1);
    chk("s1_c1_pdata", bus.data_pdata_o, RD);
    chk("s1_c1_addr", 64'(bus.mem_addr_o), 64'h10004);
    chk("s1_c1_inst_data", 64'(bus.inst_data_o), 64'hAAAABBBB);
    @(negedge clk);

    // Streak limit: four stores, one fetch, repeat.
    do_reset();
    bus.inst_valid_i = 1'b1; bus.inst_addr_i = 32'h10000;
    bus.data_qvalid_i = 1'b1; bus.data_qwrite_i = 1'b1; bus.data_qaddr_i = 32'h200;
    bus.data_qstrb_i = 8'hFF; bus.data_qdata_i = WD; bus.mem_ready_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #2;
      chk($sformatf("s2_c%0d_write", c), 64'(bus.mem_write_o), 64'((c % 5) != 4));
      chk($sformatf("s2_c%0d_inst_ready", c), 64'(bus.inst_ready_o), 64'((c % 5) == 4));
      @(negedge clk);
    end

    // Response back-pressure: second load waits, fetch proceeds.
    do_reset();
    bus.data_qvalid_i = 1'b1; bus.data_qaddr_i = 32'h100;
    bus.mem_ready_i = 1'b1; bus.mem_rdata_i = R1;
    #2;
    chk("s3_first_qready", 64'(bus.data_qready_o), 64'd1);
    @(negedge clk);
    bus.data_qaddr_i = 32'h108; bus.mem_rdata_i = R2;
    bus.inst_valid_i = 1'b1; bus.inst_addr_i = 32'h10000;
    for (int c = 0; c < 3; c++) begin
      #2;
      chk($sformatf("s3_hold%0d_pvalid", c), 64'(bus.data_pvalid_o), 64'd1);
      chk($sformatf("s3_hold%0d_pdata", c), bus.data_pdata_o, R1);
      chk($sformatf("s3_hold%0d_addr", c), 64'(bus.mem_addr_o), 64'h10000);
      chk($sformatf("s3_hold%0d_qready", c), 64'(bus.data_qready_o), 64'd0);
      @(negedge clk);
    end
    bus.data_pready_i = 1'b1;
    #2;
    chk("s3_pready_addr", 64'(bus.mem_addr_o), 64'h108);
    chk("s3_pready_qready", 64'(bus.data_qready_o), 64'd1);
    @(negedge clk);
    bus.data_qvalid_i = 1'b0; bus.data_pready_i = 1'b0;
    #2;
    chk("s3_refill_pvalid", 64'(bus.data_pvalid_o), 64'd1);
    chk("s3_refill_pdata", bus.data_pdata_o, R2);
    @(negedge clk);

    // Lock hold: stalled fetch keeps the port while a store waits.
    do_reset();
    bus.inst_valid_i = 1'b1; bus.inst_addr_i = 32'h10008; bus.mem_rdata_i = RD;
    #2;
    chk("s4_c0_addr", 64'(bus.mem_addr_o), 64'h10008);
    @(negedge clk);
    bus.data_qvalid_i = 1'b1; bus.data_qwrite_i = 1'b1; bus.data_qaddr_i = 32'h200;
    bus.data_qstrb_i = 8'hF0; bus.data_qdata_i = WD;
    for (int c = 1; c < 5; c++) begin
      #2;
      chk($sformatf("s4_c%0d_addr", c), 64'(bus.mem_addr_o), 64'h10008);
      chk($sformatf("s4_c%0d_inst_ready", c), 64'(bus.inst_ready_o), 64'd0);
      @(negedge clk);
    end
    bus.mem_ready_i = 1'b1;
    #2;
    chk("s4_done_inst_ready", 64'(bus.inst_ready_o), 64'd1);
    chk("s4_done_inst_data", 64'(bus.inst_data_o), 64'hCCCCDDDD);
    chk("s4_done_qready", 64'(bus.data_qready_o), 64'd0);
    @(negedge clk);
    bus.inst_valid_i = 1'b0;
    #2;
    chk("s4_store_addr", 64'(bus.mem_addr_o), 64'h200);
    chk("s4_store_wstrb", 64'(bus.mem_wstrb_o), 64'hF0);
    chk("s4_store_qready", 64'(bus.data_qready_o), 64'd1);
    @(negedge clk);

    // AMO: no memory access, error response with zero data.
    do_reset();
    bus.data_qvalid_i = 1'b1; bus.data_qamo_i = 4'h2; bus.data_qaddr_i = 32'h400;
    bus.mem_ready_i = 1'b1;
    #2;
    chk("s5_mem_valid", 64'(bus.mem_valid_o), 64'd0);
    chk("s5_qready", 64'(bus.data_qready_o), 64'd1);
    @(negedge clk);
    bus.data_qvalid_i = 1'b0; bus.data_qamo_i = 4'h0;
    #2;
    chk("s5_pvalid", 64'(bus.data_pvalid_o), 64'd1);
    chk("s5_perror", 64'(bus.data_perror_o), 64'd1);
    chk("s5_pdata", bus.data_pdata_o, 64'd0);
    @(negedge clk);

    // Async reset during a stalled store with a buffered response.
    do_reset();
    bus.data_qvalid_i = 1'b1; bus.data_qaddr_i = 32'h100;
    bus.mem_ready_i = 1'b1; bus.mem_rdata_i = R1;
    @(negedge clk);
    bus.data_qwrite_i = 1'b1; bus.data_qaddr_i = 32'h300; bus.data_qstrb_i = 8'hFF;
    bus.mem_ready_i = 1'b0;
    #2;
    chk("s6_pre_addr", 64'(bus.mem_addr_o), 64'h300);
    chk("s6_pre_pvalid", 64'(bus.data_pvalid_o), 64'd1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("s6_rst_mem_valid", 64'(bus.mem_valid_o), 64'd0);
    chk("s6_rst_mem_addr", 64'(bus.mem_addr_o), 64'd0);
    chk("s6_rst_pvalid", 64'(bus.data_pvalid_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk("s6_rel_mem_valid", 64'(bus.mem_valid_o), 64'd1);
    chk("s6_rel_addr", 64'(bus.mem_addr_o), 64'h300);
    chk("s6_rel_pvalid", 64'(bus.data_pvalid_o), 64'd0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
